// File: rtl/mismatch_monitor_pkg.sv
// Shared types and default sizing for the mismatch monitor.
// Build option MISMATCH_MONITOR_BITMASK_EN (see mismatch_monitor.sv) does not affect this file.
package mismatch_monitor_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mismatch_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/mismatch_monitor.sv
// Windowed ref/dut comparator: counts samples and failures between start and stop,
// latching the index of the first failure. Define MISMATCH_MONITOR_BITMASK_EN to add err_mask.
module mismatch_monitor
    import mismatch_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] ref_q,
    input  logic [WIDTH-1:0] dut_q,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             first_err_valid
`ifdef MISMATCH_MONITOR_BITMASK_EN
    ,
    output logic [WIDTH-1:0] err_mask
`endif
);

    state_t state, state_nxt;
    logic   counted;
    logic   failing;
    logic   err_hit;

    // A start cycle only opens the window; its sample belongs to no window.
    assign counted = sample_en && (state == RUN) && !start;
    assign failing = (ref_q != dut_q);
    assign err_hit = counted && failing;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = RUN;
        end else if (stop && (state == RUN)) begin
            state_nxt = DONE;
        end
    end

    // state is a register, so these decode outputs carry no combinational input path.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    sat_counter #(.W(CNT_W)) u_sample_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (counted),
        .q     (sample_count)
    );

    sat_counter #(.W(CNT_W)) u_error_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .en    (err_hit),
        .q     (error_count)
    );

    always_ff @(posedge clk) begin
        if (reset || start) begin
            mismatch        <= 1'b0;
            first_err_idx   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            mismatch <= err_hit;
            if (err_hit && !first_err_valid) begin
                first_err_idx   <= sample_count;
                first_err_valid <= 1'b1;
            end
        end
    end

`ifdef MISMATCH_MONITOR_BITMASK_EN
    always_ff @(posedge clk) begin
        if (reset || start) begin
            err_mask <= '0;
        end else if (counted) begin
            err_mask <= err_mask | (ref_q ^ dut_q);
        end
    end
`endif

endmodule
